riscv_multicycle_ctrl: RTL and testbench



---
 rtl/riscv_pkg.sv | 75 +++++++
 rtl/riscv_ctrl_watchdog.sv | 39 +++
 rtl/riscv_multicycle_ctrl.sv | 158 +++++++++++++++
 tb/tb_riscv_multicycle_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types and opcode constants for the toy RV32I multi-cycle core.
// Decoder, control FSM and datapath all agree on these encodings.
package riscv_pkg;

  typedef enum logic [2:0] {
    R_TYPE       = 3'd0,
    I_TYPE       = 3'd1,
    S_TYPE       = 3'd2,
    B_TYPE       = 3'd3,
    U_TYPE       = 3'd4,
    J_TYPE       = 3'd5,
    UNKNOWN_TYPE = 3'd7
  } instruction_type_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEM       = 3'd3,
    WRITEBACK = 3'd4,
    TRAP      = 3'd5
  } ctrl_state_e;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'd0,
    PC_BR_JAL = 2'd1,
    PC_JALR   = 2'd2
  } pc_src_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  function automatic logic is_rv32i_opcode(input logic [6:0] opc);
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
      OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

  function automatic imm_type_e imm_for_type(input instruction_type_e t);
    case (t)
      I_TYPE:  return IMM_I;
      S_TYPE:  return IMM_S;
      B_TYPE:  return IMM_B;
      U_TYPE:  return IMM_U;
      J_TYPE:  return IMM_J;
      default: return IMM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/riscv_ctrl_watchdog.sv
// Memory-request watchdog: counts stalled request cycles and flags expiry
// when the count reaches MEM_TIMEOUT with the request still unanswered.
module riscv_ctrl_watchdog #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TIMEOUT_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam logic [TIMEOUT_W-1:0] LIMIT   = TIMEOUT_W'(MEM_TIMEOUT);
  localparam logic                 ENABLED = (MEM_TIMEOUT != 0);

  logic [TIMEOUT_W-1:0] count_q, count_d;

  // Saturate at the limit so a disabled watchdog (limit 0) never moves.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_en && (count_q != LIMIT)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = ENABLED && count_en && (count_q == LIMIT);

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle control FSM for the toy RV32I core: sequences fetch, decode,
// execute, memory and writeback and drives the datapath enables and selects.
module riscv_multicycle_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TIMEOUT_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] instr_type,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  output logic       imem_req,
  input  logic       imem_ack,
  output logic       dmem_req,
  output logic       dmem_we,
  input  logic       dmem_ack,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic [2:0] imm_sel,
  output logic       alu_a_sel,
  output logic       alu_b_sel,
  output logic       rf_we,
  output logic [1:0] wb_sel,
  output logic       illegal,
  output logic [2:0] state_o
);

  ctrl_state_e state_q, state_d;
  logic        wd_count_en;
  logic        wd_expired;

  assign wd_count_en = ((state_q == FETCH) && !imem_ack) || ((state_q == MEM) && !dmem_ack);

  riscv_ctrl_watchdog #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TIMEOUT_W   (TIMEOUT_W)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear    (state_d != state_q),
    .count_en (wd_count_en),
    .expired  (wd_expired)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every output gets a default before the case, so no path through
  // this block leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = PC_PLUS4;
    imm_sel   = IMM_NONE;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = WB_ALU;
    illegal   = 1'b0;
    state_o   = state_q;

    if (state_q inside {DECODE, EXECUTE, MEM, WRITEBACK}) begin
      imm_sel   = imm_for_type(instruction_type_e'(instr_type));
      alu_a_sel = opcode inside {OPC_AUIPC, OPC_JAL, OPC_BRANCH};
      alu_b_sel = !(opcode inside {OPC_OP, OPC_BRANCH});
    end

    case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we   = 1'b1;
          state_d = DECODE;
        end else if (wd_expired) begin
          state_d = TRAP;
        end
      end
      DECODE: begin
        if ((instr_type == UNKNOWN_TYPE) || !is_rv32i_opcode(opcode)) begin
          state_d = TRAP;
        end else begin
          state_d = EXECUTE;
        end
      end
      EXECUTE: begin
        if (opcode inside {OPC_LOAD, OPC_STORE}) begin
          state_d = MEM;
        end else if (opcode == OPC_BRANCH) begin
          pc_we   = 1'b1;
          pc_src  = branch_taken ? PC_BR_JAL : PC_PLUS4;
          state_d = FETCH;
        end else begin
          state_d = WRITEBACK;
        end
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (opcode == OPC_STORE);
        if (dmem_ack) begin
          if (opcode == OPC_STORE) begin
            pc_we   = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WRITEBACK;
          end
        end else if (wd_expired) begin
          state_d = TRAP;
        end
      end
      WRITEBACK: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        state_d = FETCH;
        case (opcode)
          OPC_LOAD: wb_sel = WB_MEM;
          OPC_JAL:  begin wb_sel = WB_PC4; pc_src = PC_BR_JAL; end
          OPC_JALR: begin wb_sel = WB_PC4; pc_src = PC_JALR;   end
          OPC_LUI:  wb_sel = WB_IMM;
          default:  wb_sel = WB_ALU;
        endcase
      end
      TRAP:    illegal = 1'b1;
      default: state_d = FETCH;
    endcase

    // Reset silences the whole interface immediately, not just from the next edge.
    if (rst) begin
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_src    = PC_PLUS4;
      imm_sel   = IMM_NONE;
      alu_a_sel = 1'b0;
      alu_b_sel = 1'b0;
      rf_we     = 1'b0;
      wb_sel    = WB_ALU;
      illegal   = 1'b0;
      state_o   = FETCH;
    end
  end

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Directed bench for riscv_multicycle_ctrl: walks each instruction class,
// the trap path, the fetch watchdog and reset during a data access.
module tb_riscv_multicycle_ctrl;
  import riscv_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] instr_type;
  logic [6:0] opcode;
  logic       branch_taken;
  logic       imem_req, imem_ack;
  logic       dmem_req, dmem_we, dmem_ack;
  logic       ir_we, pc_we, alu_a_sel, alu_b_sel, rf_we, illegal;
  logic [1:0] pc_src, wb_sel;
  logic [2:0] imm_sel, state_o;

  int total = 0;
  int bad   = 0;

  riscv_multicycle_ctrl #(.MEM_TIMEOUT(4), .TIMEOUT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_type   (instr_type),
    .opcode       (opcode),
    .branch_taken (branch_taken),
    .imem_req     (imem_req),
    .imem_ack     (imem_ack),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_ack     (dmem_ack),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_src       (pc_src),
    .imm_sel      (imm_sel),
    .alu_a_sel    (alu_a_sel),
    .alu_b_sel    (alu_b_sel),
    .rf_we        (rf_we),
    .wb_sel       (wb_sel),
    .illegal      (illegal),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL time_limit: simulation still running at %0t, required finish", $time);
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply inputs after the falling edge, then let outputs settle before checking.
  task automatic drive(input logic r, input logic [2:0] it, input logic [6:0] opc,
                       input logic br, input logic ia, input logic da);
    @(negedge clk);
    rst = r; instr_type = it; opcode = opc; branch_taken = br;
    imem_ack = ia; dmem_ack = da;
    #1;
  endtask

  task automatic expect_cyc(input string tag, input logic [2:0] st,
                            input logic ireq, input logic irwe, input logic dreq,
                            input logic dwe, input logic pcwe, input logic [1:0] pcsrc,
                            input logic rfwe, input logic [1:0] wbsel, input logic ill);
    check({tag, "/state"},    32'(state_o),  32'(st));
    check({tag, "/imem_req"}, 32'(imem_req), 32'(ireq));
    check({tag, "/ir_we"},    32'(ir_we),    32'(irwe));
    check({tag, "/dmem_req"}, 32'(dmem_req), 32'(dreq));
    check({tag, "/dmem_we"},  32'(dmem_we),  32'(dwe));
    check({tag, "/pc_we"},    32'(pc_we),    32'(pcwe));
    check({tag, "/pc_src"},   32'(pc_src),   32'(pcsrc));
    check({tag, "/rf_we"},    32'(rf_we),    32'(rfwe));
    check({tag, "/wb_sel"},   32'(wb_sel),   32'(wbsel));
    check({tag, "/illegal"},  32'(illegal),  32'(ill));
  endtask

  task automatic expect_sel(input string tag, input logic [2:0] imm,
                            input logic a, input logic b);
    check({tag, "/imm_sel"},   32'(imm_sel),   32'(imm));
    check({tag, "/alu_a_sel"}, 32'(alu_a_sel), 32'(a));
    check({tag, "/alu_b_sel"}, 32'(alu_b_sel), 32'(b));
  endtask

  initial begin
    rst = 1'b1; instr_type = I_TYPE; opcode = OPC_OPIMM;
    branch_taken = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;

    // Reset with acks high: every output must still read 0.
    drive(1, I_TYPE, OPC_OPIMM, 0, 1, 1);
    expect_cyc("rst", FETCH, 0, 0, 0, 0, 0, PC_PLUS4, 0, WB_ALU, 0);
    expect_sel("rst", IMM_NONE, 0, 0);
    drive(1, I_TYPE, OPC_OPIMM, 0, 1, 1);

    // ADDI
    drive(0, I_TYPE, OPC_OPIMM, 0, 1, 0);
    expect_cyc("addi.f", FETCH, 1, 1, 0, 0, 0, PC_PLUS4, 0, WB_ALU, 0);
    expect_sel("addi.f", IMM_NONE, 0, 0);
    drive(0, I_TYPE, OPC_OPIMM, 0, 0, 0);
    expect_cyc("addi.d", DECODE, 0, 0, 0, 0, 0, PC_PLUS4, 0, WB_ALU, 0);
    expect_sel("addi.d", IMM_I, 0, 1);
    drive(0, I_TYPE, OPC_OPIMM, 0, 0, 0);
    expect_cyc("addi.e", EXECUTE, 0, 0, 0, 0, 0, PC_PLUS4, 0, WB_ALU, 0);
    drive(0, I_TYPE, OPC_OPIMM, 0, 0, 0);
    expect_cyc("addi.w", WRITEBACK, 0, 0, 0, 0, 1, PC_PLUS4, 1, WB_ALU, 0);
    drive(0, I_TYPE, OPC_OPIMM, 0, 0, 0);
    expect_cyc("addi.f2", FETCH, 1, 0, 0, 0, 0, PC_PLUS4, 0, WB_ALU, 0);

    // LW, dmem_ack three cycles late
    drive(0, I_TYPE, OPC_LOAD, 0, 1, 0);
    expect_cyc("lw.f", FETCH, 1, 1, 0, 0, 0, PC_PLUS4, 0, WB_ALU, 0);
    drive(0, I_TYPE, OPC_LOAD, 0, 0, 0);
    expect_cyc("lw.d", DECODE, 0, 0, 0, 0, 0, PC_PLUS4, 0, WB_ALU, 0);
    drive(0, I_TYPE, OPC_LOAD, 0, 0, 0);
    expect_sel("lw.e", IMM_I, 0, 1);
    for (int i = 0; i < 3; i++) begin
      drive(0, I_TYPE, OPC_LOAD, 0, 0, 0);
      expect_cyc($sformatf("lw.m%0d", i), MEM, 0, 0, 1, 0, 0, PC_PLUS4, 0, WB_ALU, 0);
    end
    drive(0, I_TYPE, OPC_LOAD, 0, 0, 1);
    expect_cyc("lw.m3", MEM, 0, 0, 1, 0, 0, PC_PLUS4, 0, WB_ALU, 0);
    drive(0, I_TYPE, OPC_LOAD, 0, 0, 0);
    expect_cyc("lw.w", WRITEBACK, 0, 0, 0, 0, 1, PC_PLUS4, 1, WB_MEM, 0);

    // SW
    drive(0, S_TYPE, OPC_STORE, 0, 1, 0);
    expect_cyc("sw.f", FETCH, 1, 1, 0, 0, 0, PC_PLUS4, 0, WB_ALU, 0);
    drive(0, S_TYPE, OPC_STORE, 0, 0, 0);
    expect_sel("sw.d", IMM_S, 0, 1);
    drive(0, S_TYPE, OPC_STORE, 0, 0, 0);
    expect_cyc("sw.e", EXECUTE, 0, 0, 0, 0, 0, PC_PLUS4, 0, WB_ALU, 0);
    drive(0, S_TYPE, OPC_STORE, 0, 0, 1);
    expect_cyc("sw.m", MEM, 0, 0, 1, 1, 1, PC_PLUS4, 0, WB_ALU, 0);

    // BEQ taken, then not taken
    for (int t = 1; t >= 0; t--) begin
      drive(0, B_TYPE, OPC_BRANCH, t[0], 1, 0);
      expect_cyc($sformatf("br%0d.f", t), FETCH, 1, 1, 0, 0, 0, PC_PLUS4, 0, WB_ALU, 0);
      drive(0, B_TYPE, OPC_BRANCH, t[0], 0, 0);
      expect_sel($sformatf("br%0d.d", t), IMM_B, 1, 0);
      drive(0, B_TYPE, OPC_BRANCH, t[0], 0, 0);
      expect_cyc($sformatf("br%0d.e", t), EXECUTE, 0, 0, 0, 0, 1,
                 t[0] ? PC_BR_JAL : PC_PLUS4, 0, WB_ALU, 0);
    end

    // JAL, JALR, LUI: FETCH/DECODE/EXECUTE/WRITEBACK
    drive(0, J_TYPE, OPC_JAL, 0, 1, 0);
    expect_cyc("jal.f", FETCH, 1, 1, 0, 0, 0, PC_PLUS4, 0, WB_ALU, 0);
    drive(0, J_TYPE, OPC_JAL, 0, 0, 0);
    drive(0, J_TYPE, OPC_JAL, 0, 0, 0);
    expect_sel("jal.e", IMM_J, 1, 1);
    drive(0, J_TYPE, OPC_JAL, 0, 0, 0);
    expect_cyc("jal.w", WRITEBACK, 0, 0, 0, 0, 1, PC_BR_JAL, 1, WB_PC4, 0);

    drive(0, I_TYPE, OPC_JALR, 0, 1, 0);
    drive(0, I_TYPE, OPC_JALR, 0, 0, 0);
    drive(0, I_TYPE, OPC_JALR, 0, 0, 0);
    expect_sel("jalr.e", IMM_I, 0, 1);
    drive(0, I_TYPE, OPC_JALR, 0, 0, 0);
    expect_cyc("jalr.w", WRITEBACK, 0, 0, 0, 0, 1, PC_JALR, 1, WB_PC4, 0);

    drive(0, U_TYPE, OPC_LUI, 0, 1, 0);
    drive(0, U_TYPE, OPC_LUI, 0, 0, 0);
    expect_sel("lui.d", IMM_U, 0, 1);
    drive(0, U_TYPE, OPC_LUI, 0, 0, 0);
    drive(0, U_TYPE, OPC_LUI, 0, 0, 0);
    expect_cyc("lui.w", WRITEBACK, 0, 0, 0, 0, 1, PC_PLUS4, 1, WB_IMM, 0);

    // Unknown instruction: trap, held with acks toggling, cleared by rst
    drive(0, UNKNOWN_TYPE, 7'h7F, 0, 1, 0);
    expect_cyc("unk.f", FETCH, 1, 1, 0, 0, 0, PC_PLUS4, 0, WB_ALU, 0);
    drive(0, UNKNOWN_TYPE, 7'h7F, 0, 0, 0);
    expect_cyc("unk.d", DECODE, 0, 0, 0, 0, 0, PC_PLUS4, 0, WB_ALU, 0);
    for (int i = 0; i < 20; i++) begin
      logic [1:0] ak;
      ak = 2'(i);
      drive(0, UNKNOWN_TYPE, 7'h7F, 1, ak[0], ak[1]);
      expect_cyc($sformatf("trap%0d", i), TRAP, 0, 0, 0, 0, 0, PC_PLUS4, 0, WB_ALU, 1);
    end
    expect_sel("trap", IMM_NONE, 0, 0);
    drive(1, UNKNOWN_TYPE, 7'h7F, 0, 0, 0);
    expect_cyc("trap.rst", FETCH, 0, 0, 0, 0, 0, PC_PLUS4, 0, WB_ALU, 0);
    drive(0, I_TYPE, 7'b0001111, 0, 0, 0);
    expect_cyc("trap.after", FETCH, 1, 0, 0, 0, 0, PC_PLUS4, 0, WB_ALU, 0);

    // Valid type but opcode outside the base set
    drive(0, I_TYPE, 7'b0001111, 0, 1, 0);
    drive(0, I_TYPE, 7'b0001111, 0, 0, 0);
    expect_cyc("fence.d", DECODE, 0, 0, 0, 0, 0, PC_PLUS4, 0, WB_ALU, 0);
    drive(0, I_TYPE, 7'b0001111, 0, 0, 0);
    expect_cyc("fence.t", TRAP, 0, 0, 0, 0, 0, PC_PLUS4, 0, WB_ALU, 1);

    // Fetch watchdog: no ack -> trap after 5 FETCH cycles
    drive(1, I_TYPE, OPC_OPIMM, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(0, I_TYPE, OPC_OPIMM, 0, 0, 0);
      expect_cyc($sformatf("wd.f%0d", i), FETCH, 1, 0, 0, 0, 0, PC_PLUS4, 0, WB_ALU, 0);
    end
    drive(0, I_TYPE, OPC_OPIMM, 0, 0, 0);
    expect_cyc("wd.trap", TRAP, 0, 0, 0, 0, 0, PC_PLUS4, 0, WB_ALU, 1);

    // Ack exactly at the timeout count wins
    drive(1, I_TYPE, OPC_OPIMM, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, I_TYPE, OPC_OPIMM, 0, 0, 0);
    drive(0, I_TYPE, OPC_OPIMM, 0, 1, 0);
    expect_cyc("wd.ack", FETCH, 1, 1, 0, 0, 0, PC_PLUS4, 0, WB_ALU, 0);
    drive(0, I_TYPE, OPC_OPIMM, 0, 0, 0);
    expect_cyc("wd.dec", DECODE, 0, 0, 0, 0, 0, PC_PLUS4, 0, WB_ALU, 0);
    drive(0, I_TYPE, OPC_OPIMM, 0, 0, 0);
    drive(0, I_TYPE, OPC_OPIMM, 0, 0, 0);
    expect_cyc("wd.wb", WRITEBACK, 0, 0, 0, 0, 1, PC_PLUS4, 1, WB_ALU, 0);

    // Reset during a load access; a late ack afterwards is ignored
    drive(0, I_TYPE, OPC_LOAD, 0, 1, 0);
    drive(0, I_TYPE, OPC_LOAD, 0, 0, 0);
    drive(0, I_TYPE, OPC_LOAD, 0, 0, 0);
    drive(0, I_TYPE, OPC_LOAD, 0, 0, 0);
    expect_cyc("rstm.m", MEM, 0, 0, 1, 0, 0, PC_PLUS4, 0, WB_ALU, 0);
    drive(1, I_TYPE, OPC_LOAD, 0, 0, 1);
    expect_cyc("rstm.rst", FETCH, 0, 0, 0, 0, 0, PC_PLUS4, 0, WB_ALU, 0);
    drive(0, I_TYPE, OPC_LOAD, 0, 0, 1);
    expect_cyc("rstm.f", FETCH, 1, 0, 0, 0, 0, PC_PLUS4, 0, WB_ALU, 0);
    drive(0, I_TYPE, OPC_LOAD, 0, 0, 0);
    expect_cyc("rstm.f2", FETCH, 1, 0, 0, 0, 0, PC_PLUS4, 0, WB_ALU, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
